// File: rtl/fp25_pkg.sv
// Shared types and helpers for the fp(2,5) MAC scheduler: operand packing,
// result width and the round-robin pick used by the arbiter.
package fp25_pkg;

   localparam int FP25_OP_W  = 10;
   localparam int FP25_RES_W = 20;

   typedef struct packed {
      logic       sign;
      logic       denorm;
      logic [2:0] exp;
      logic [4:0] man;
   } fp25_op_t;

   // One-hot grant of the first valid bit at or after ptr, wrapping at n (n <= 8).
   function automatic logic [7:0] rr_pick(input logic [7:0] valid,
                                          input logic [2:0] ptr,
                                          input logic [3:0] n);
      logic [7:0] grant;
      logic       found;
      logic [3:0] idx;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = {1'b0, ptr} + 4'(i);
         if (idx >= n) idx = idx - n;
         if ((4'(i) < n) && !found && valid[idx[2:0]]) begin
            grant[idx[2:0]] = 1'b1;
            found = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/fp25_res_fifo.sv
// Show-ahead circular result FIFO with synchronous reset and an occupancy count.
// Push and pop may coincide, including when full (the slot written is the head being consumed).
module fp25_res_fifo #(
   parameter  int WIDTH = 22,
   parameter  int DEPTH = 8,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign w_doPop  = i_pop && (r_count != '0);
   assign w_doPush = i_push && ((r_count != CNT_W'(DEPTH)) || w_doPop);

   always_ff @(posedge clk) begin
      if (w_doPush) r_mem[r_wrPtr] <= i_din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush)
            r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + PTR_W'(1);
         if (w_doPop)
            r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + PTR_W'(1);
         if (w_doPush && !w_doPop)
            r_count <= r_count + CNT_W'(1);
         else if (!w_doPush && w_doPop)
            r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_dout  = r_mem[r_rdPtr];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/fp25_mac_sched.sv
// Round-robin scheduler sharing one fp(2,5) multiply-add pipe among NUM_REQ requesters.
// Issues only with a guaranteed FIFO slot, so returning results can never be dropped.
module fp25_mac_sched
   import fp25_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int MAC_LAT    = 3,
   parameter  int FIFO_DEPTH = 8,
   localparam int TAG_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*3*FP25_OP_W-1:0] req_op,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [FP25_OP_W-1:0]           mac_a,
   output logic [FP25_OP_W-1:0]           mac_b,
   output logic [FP25_OP_W-1:0]           mac_c,
   input  logic [FP25_RES_W-1:0]          mac_res,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [FP25_RES_W-1:0]          out_res,
   output logic [TAG_W-1:0]               out_tag,
   output logic                           busy
);

   fp25_op_t                        r_macA, r_macB, r_macC;
   logic [TAG_W-1:0]                r_rrPtr;
   logic [MAC_LAT:0]                r_tagVld;
   logic [MAC_LAT:0][TAG_W-1:0]     r_tagIdx;
   logic [CNT_W-1:0]                r_inflight;
   logic [CNT_W-1:0]                w_fifoCnt;
   logic [CNT_W:0]                  w_used;
   logic                            w_hasCredit;
   logic [7:0]                      w_pick;
   logic [NUM_REQ-1:0]              w_grant;
   logic [TAG_W-1:0]                w_grantIdx;
   logic [3*FP25_OP_W-1:0]          w_grantOp;
   logic                            w_issue;
   logic                            w_retire;
   logic                            w_fifoPush;
   logic                            w_fifoPop;
   logic                            w_fifoEmpty;
   logic [FP25_RES_W+TAG_W-1:0]     w_fifoDout;

   // Credit uses registered counts only, so a pop frees a slot one cycle later.
   assign w_used      = {1'b0, w_fifoCnt} + {1'b0, r_inflight};
   assign w_hasCredit = (w_used < (CNT_W + 1)'(FIFO_DEPTH));
   assign w_pick      = rr_pick(8'(req_valid), 3'(r_rrPtr), 4'(NUM_REQ));
   assign w_grant     = (w_hasCredit && !rst) ? NUM_REQ'(w_pick) : '0;
   assign req_ready   = w_grant;
   assign w_issue     = |(req_valid & w_grant);

   always_comb begin
      w_grantIdx = '0;
      w_grantOp  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_grantIdx = TAG_W'(i);
            w_grantOp  = req_op[i*3*FP25_OP_W +: 3*FP25_OP_W];
         end
      end
   end

   // Stage 0 travels with the operand registers; stage MAC_LAT lines up with mac_res.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_macA   <= '0;
         r_macB   <= '0;
         r_macC   <= '0;
         r_rrPtr  <= '0;
         r_tagVld <= '0;
         r_tagIdx <= '0;
      end else begin
         r_tagVld <= {r_tagVld[MAC_LAT-1:0], w_issue};
         r_tagIdx <= {r_tagIdx[MAC_LAT-1:0], w_grantIdx};
         if (w_issue) begin
            {r_macC, r_macB, r_macA} <= w_grantOp;
            r_rrPtr <= (w_grantIdx == TAG_W'(NUM_REQ - 1)) ? '0 : w_grantIdx + TAG_W'(1);
         end
      end
   end

   assign w_retire = r_tagVld[MAC_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= '0;
      end else begin
         case ({w_issue, w_retire})
            2'b10:   r_inflight <= r_inflight + CNT_W'(1);
            2'b01:   r_inflight <= r_inflight - CNT_W'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   assign w_fifoPush = w_retire;
   assign w_fifoPop  = out_valid && out_ready;

   fp25_res_fifo #(
      .WIDTH (FP25_RES_W + TAG_W),
      .DEPTH (FIFO_DEPTH)
   ) u_resFifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_fifoPush),
      .i_din   ({mac_res, r_tagIdx[MAC_LAT]}),
      .i_pop   (w_fifoPop),
      .o_dout  (w_fifoDout),
      .o_empty (w_fifoEmpty),
      .o_count (w_fifoCnt)
   );

   assign mac_a     = r_macA;
   assign mac_b     = r_macB;
   assign mac_c     = r_macC;
   assign out_valid = !w_fifoEmpty;
   assign out_res   = w_fifoDout[FP25_RES_W+TAG_W-1:TAG_W];
   assign out_tag   = w_fifoDout[TAG_W-1:0];
   assign busy      = (r_inflight != '0) || !w_fifoEmpty;

endmodule

// File: tb/tb_fp25_mac_sched.sv
// Directed bench for fp25_mac_sched with a behavioural MAC of fixed latency
// and a standalone result-FIFO instance for the full push+pop case.
module tb_fp25_mac_sched;

   localparam int NUM_REQ    = 4;
   localparam int MAC_LAT    = 3;
   localparam int FIFO_DEPTH = 8;
   localparam int TAG_W      = 2;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NUM_REQ-1:0]     reqValid = '0;
   logic [NUM_REQ*30-1:0]  reqOp = '0;
   logic [NUM_REQ-1:0]     reqReady;
   logic [9:0]             macA, macB, macC;
   logic [19:0]            macRes = '0;
   logic                   outValid;
   logic                   outReady = 1'b0;
   logic [19:0]            outRes;
   logic [TAG_W-1:0]       outTag;
   logic                   busy;

   logic                   fPush = 1'b0;
   logic                   fPop = 1'b0;
   logic [19:0]            fDin = '0;
   logic [19:0]            fDout;
   logic                   fEmpty;
   logic [3:0]             fCount;

   int                     checks = 0;
   int                     errors = 0;
   logic [TAG_W+19:0]      expQ[$];
   logic [29:0]            hist [0:MAC_LAT];

   always #5 clk = ~clk;

   fp25_mac_sched #(
      .NUM_REQ    (NUM_REQ),
      .MAC_LAT    (MAC_LAT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (reqValid),
      .req_op    (reqOp),
      .req_ready (reqReady),
      .mac_a     (macA),
      .mac_b     (macB),
      .mac_c     (macC),
      .mac_res   (macRes),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_res   (outRes),
      .out_tag   (outTag),
      .busy      (busy)
   );

   fp25_res_fifo #(
      .WIDTH (20),
      .DEPTH (FIFO_DEPTH)
   ) u_fifoUnit (
      .clk     (clk),
      .rst     (rst),
      .i_push  (fPush),
      .i_din   (fDin),
      .i_pop   (fPop),
      .o_dout  (fDout),
      .o_empty (fEmpty),
      .o_count (fCount)
   );

   function automatic logic [29:0] mkOp(input int i, input int k);
      logic [9:0] a, b, c;
      a = 10'(i * 97 + k * 13);
      b = 10'(k * 31 + 5 + i);
      c = 10'(i * 7 + k * 211 + 1);
      return {c, b, a};
   endfunction

   // Stand-in for the MAC datapath: any fixed map of the operands exposes routing errors.
   function automatic logic [19:0] expRes(input logic [29:0] op);
      return {op[9:0], op[19:10] ^ op[29:20]};
   endfunction

   // Operands seen in cycle n produce mac_res in cycle n+MAC_LAT.
   initial begin
      for (int i = 0; i <= MAC_LAT; i++) hist[i] = '0;
      forever begin
         @(negedge clk);
         for (int i = MAC_LAT; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = {macC, macB, macA};
         macRes  = expRes(hist[MAC_LAT]);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && dut.w_fifoPush && !dut.w_fifoPop && (dut.w_fifoCnt == 4'(FIFO_DEPTH))) begin
            errors++;
            $display("[TB] FAIL fifo_overflow push into full FIFO at %0t", $time);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      rst      = 1'b1;
      reqValid = '0;
      outReady = 1'b0;
      fPush    = 1'b0;
      fPop     = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      expQ.delete();
   endtask

   task automatic test_reset();
      applyReset();
      #1;
      checks++;
      if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got=%b exp=0", outValid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
      checks++;
      if ({macC, macB, macA} !== 30'h0) begin errors++; $display("[TB] FAIL rst_mac got=%h exp=0", {macC, macB, macA}); end
      reqValid = 4'b0001;
      reqOp[29:0] = mkOp(0, 50);
      outReady = 1'b1;
      #1;
      checks++;
      if (reqReady !== 4'b0001) begin errors++; $display("[TB] FAIL rst_pre_grant got=%b exp=0001", reqReady); end
      cyc();
      cyc();
      rst = 1'b1;
      #1;
      checks++;
      if (reqReady !== 4'b0000) begin errors++; $display("[TB] FAIL rst_ready_in_reset got=%b exp=0000", reqReady); end
      cyc();
      rst = 1'b0;
      reqValid = '0;
      #1;
      checks++;
      if (outValid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL rst_midstream valid=%b busy=%b exp 0 0", outValid, busy);
      end
      checks++;
      if ({macC, macB, macA} !== 30'h0) begin errors++; $display("[TB] FAIL rst_midstream_mac got=%h exp=0", {macC, macB, macA}); end
      for (int c = 0; c < 8; c++) begin
         cyc();
         checks++;
         if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_stale_push c=%0d out_valid=%b exp=0", c, outValid); end
      end
   endtask

   task automatic test_single();
      logic [29:0] op;
      applyReset();
      op = {10'h020, 10'h020, 10'h020};
      outReady = 1'b1;
      reqValid = 4'b0001;
      reqOp[29:0] = op;
      #1;
      checks++;
      if (reqReady !== 4'b0001) begin errors++; $display("[TB] FAIL single_grant got=%b exp=0001", reqReady); end
      cyc();
      reqValid = '0;
      #1;
      checks++;
      if ({macC, macB, macA} !== op) begin errors++; $display("[TB] FAIL single_mac got=%h exp=%h", {macC, macB, macA}, op); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got=%b exp=1", busy); end
      for (int k = 1; k <= MAC_LAT; k++) begin
         cyc();
         checks++;
         if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL single_early k=%0d out_valid=%b exp=0", k, outValid); end
      end
      cyc();
      checks++;
      if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL single_latency out_valid=%b exp=1", outValid); end
      checks++;
      if (outTag !== 2'd0) begin errors++; $display("[TB] FAIL single_tag got=%0d exp=0", outTag); end
      checks++;
      if (outRes !== 20'h08000) begin errors++; $display("[TB] FAIL single_res got=%h exp=08000", outRes); end
      cyc();
      checks++;
      if (outValid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL single_drain valid=%b busy=%b exp 0 0", outValid, busy);
      end
   endtask

   task automatic test_round_robin();
      int got;
      logic [TAG_W+19:0] e;
      logic [NUM_REQ-1:0] expG;
      applyReset();
      outReady = 1'b1;
      got = 0;
      for (int c = 0; c < 30; c++) begin
         if (c < 12) begin
            reqValid = '1;
            for (int i = 0; i < NUM_REQ; i++) reqOp[i*30 +: 30] = mkOp(i, c);
         end else begin
            reqValid = '0;
         end
         #1;
         if (outValid) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++; $display("[TB] FAIL rr_unexpected c=%0d tag=%0d", c, outTag);
            end else begin
               e = expQ.pop_front();
               if ({outTag, outRes} !== e) begin
                  errors++; $display("[TB] FAIL rr_result c=%0d got=%h exp=%h", c, {outTag, outRes}, e);
               end
               got++;
            end
         end else if (got > 0 && got < 12) begin
            checks++;
            errors++; $display("[TB] FAIL rr_gap c=%0d out_valid=0 exp=1", c);
         end
         if (c < 12) begin
            expG = NUM_REQ'(1) << (c % NUM_REQ);
            checks++;
            if (reqReady !== expG) begin errors++; $display("[TB] FAIL rr_grant c=%0d got=%b exp=%b", c, reqReady, expG); end
            expQ.push_back({TAG_W'(c % NUM_REQ), expRes(mkOp(c % NUM_REQ, c))});
         end
         cyc();
      end
      checks++;
      if (got != 12) begin errors++; $display("[TB] FAIL rr_count got=%0d exp=12", got); end
   endtask

   task automatic test_backpressure();
      int accepts;
      logic [NUM_REQ-1:0] expR;
      logic [TAG_W+19:0] e;
      applyReset();
      outReady = 1'b0;
      reqValid = 4'b0001;
      accepts = 0;
      for (int c = 0; c < 16; c++) begin
         reqOp[29:0] = mkOp(0, c + 100);
         #1;
         expR = (accepts < FIFO_DEPTH) ? 4'b0001 : 4'b0000;
         checks++;
         if (reqReady !== expR) begin errors++; $display("[TB] FAIL bp_fill c=%0d got=%b exp=%b", c, reqReady, expR); end
         if (expR != 0) begin
            expQ.push_back({TAG_W'(0), expRes(mkOp(0, c + 100))});
            accepts++;
         end
         cyc();
      end
      checks++;
      if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_full_valid got=%b exp=1", outValid); end
      outReady = 1'b1;
      for (int j = 0; j < 40; j++) begin
         reqValid = (j < 6) ? 4'b0001 : 4'b0000;
         reqOp[29:0] = mkOp(0, j + 200);
         #1;
         if (outValid) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++; $display("[TB] FAIL bp_unexpected j=%0d", j);
            end else begin
               e = expQ.pop_front();
               if ({outTag, outRes} !== e) begin
                  errors++; $display("[TB] FAIL bp_result j=%0d got=%h exp=%h", j, {outTag, outRes}, e);
               end
            end
         end
         if (j < 6) begin
            expR = (j == 0) ? 4'b0000 : 4'b0001;
            checks++;
            if (reqReady !== expR) begin errors++; $display("[TB] FAIL bp_credit j=%0d got=%b exp=%b", j, reqReady, expR); end
            if (expR != 0) expQ.push_back({TAG_W'(0), expRes(mkOp(0, j + 200))});
         end
         cyc();
      end
      checks++;
      if (expQ.size() != 0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL bp_drain left=%0d busy=%b exp 0 0", expQ.size(), busy);
      end
   endtask

   task automatic test_full_push_pop();
      applyReset();
      for (int v = 1; v <= FIFO_DEPTH; v++) begin
         fDin = 20'(v);
         fPush = 1'b1;
         cyc();
      end
      fPush = 1'b0;
      #1;
      checks++;
      if (fCount !== 4'(FIFO_DEPTH) || fDout !== 20'd1) begin
         errors++; $display("[TB] FAIL fifo_fill count=%0d head=%0d exp 8 1", fCount, fDout);
      end
      fDin = 20'd9;
      fPush = 1'b1;
      fPop = 1'b1;
      cyc();
      fPush = 1'b0;
      fPop = 1'b0;
      #1;
      checks++;
      if (fCount !== 4'(FIFO_DEPTH) || fDout !== 20'd2) begin
         errors++; $display("[TB] FAIL fifo_full_pushpop count=%0d head=%0d exp 8 2", fCount, fDout);
      end
      for (int v = 2; v <= 9; v++) begin
         #1;
         checks++;
         if (fDout !== 20'(v)) begin errors++; $display("[TB] FAIL fifo_order got=%0d exp=%0d", fDout, v); end
         fPop = 1'b1;
         cyc();
         fPop = 1'b0;
      end
      #1;
      checks++;
      if (fEmpty !== 1'b1) begin errors++; $display("[TB] FAIL fifo_empty got=%b exp=1", fEmpty); end
   endtask

   task automatic test_wrap_priority();
      logic [TAG_W+19:0] e;
      applyReset();
      outReady = 1'b1;
      reqValid = 4'b0010;
      reqOp[1*30 +: 30] = mkOp(1, 200);
      #1;
      checks++;
      if (reqReady !== 4'b0010) begin errors++; $display("[TB] FAIL wrap_setup got=%b exp=0010", reqReady); end
      expQ.push_back({TAG_W'(1), expRes(mkOp(1, 200))});
      cyc();
      reqValid = 4'b1010;
      reqOp[1*30 +: 30] = mkOp(1, 201);
      reqOp[3*30 +: 30] = mkOp(3, 201);
      #1;
      checks++;
      if (reqReady !== 4'b1000) begin errors++; $display("[TB] FAIL wrap_first got=%b exp=1000", reqReady); end
      expQ.push_back({TAG_W'(3), expRes(mkOp(3, 201))});
      cyc();
      reqOp[1*30 +: 30] = mkOp(1, 202);
      #1;
      checks++;
      if (reqReady !== 4'b0010) begin errors++; $display("[TB] FAIL wrap_second got=%b exp=0010", reqReady); end
      expQ.push_back({TAG_W'(1), expRes(mkOp(1, 202))});
      cyc();
      reqValid = 4'b0111;
      #1;
      checks++;
      if (reqReady !== 4'b0100) begin errors++; $display("[TB] FAIL wrap_ptr_end got=%b exp=0100", reqReady); end
      reqValid = '0;
      for (int c = 0; c < 12; c++) begin
         cyc();
         if (outValid) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++; $display("[TB] FAIL wrap_unexpected c=%0d tag=%0d", c, outTag);
            end else begin
               e = expQ.pop_front();
               if ({outTag, outRes} !== e) begin
                  errors++; $display("[TB] FAIL wrap_result c=%0d got=%h exp=%h", c, {outTag, outRes}, e);
               end
            end
         end
      end
      checks++;
      if (expQ.size() != 0) begin errors++; $display("[TB] FAIL wrap_missing left=%0d exp=0", expQ.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_full_push_pop();
      test_wrap_priority();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
